// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
// bf16_pkg
// Shared bfloat16 format constants, FSM encodings and operand classifier.
// Rev 1.0 - initial release
// ============================================================================
package bf16_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  localparam logic [15:0]      QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_INF  = 2'd1,
    CLS_NAN  = 2'd2,
    CLS_NORM = 2'd3
  } cls_e;

  // Sign-free classification; denormals collapse into zero.
  function automatic cls_e bf16_classify(input logic [EXP_W+MAN_W-1:0] mag);
    cls_e cls;
    cls = CLS_NORM;
    if (mag[EXP_W+MAN_W-1:MAN_W] == '0) begin
      cls = CLS_ZERO;
    end else if (mag[EXP_W+MAN_W-1:MAN_W] == EXP_MAX) begin
      cls = (mag[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_div_step.sv
`default_nettype none
// ============================================================================
// bf16_div_step
// One combinational restoring-division step producing a quotient bit.
// Rev 1.0 - initial release
// ============================================================================
module bf16_div_step (
  input  logic [8:0] rem_i,
  input  logic [7:0] mb_i,
  output logic [8:0] rem_next_o,
  output logic       qbit_o
);

  logic [8:0] mb9_w;
  logic [8:0] diff_w;

  assign mb9_w  = {1'b0, mb_i};
  assign qbit_o = (rem_i >= mb9_w);
  assign diff_w = qbit_o ? (rem_i - mb9_w) : rem_i;
  // diff < m_b <= 255, so the shift never loses a set bit.
  assign rem_next_o = diff_w << 1;

endmodule
`default_nettype wire

// File: rtl/bf16_div_seq.sv
`default_nettype none
// ============================================================================
// bf16_div_seq
// Sequential bfloat16 divider: 9-step restoring mantissa divide, truncation.
// Rev 1.0 - initial release
// ============================================================================
module bf16_div_seq
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] flp_a,
  input  logic [15:0] flp_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quot,
  output logic [3:0]  flags
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [7:0]        mb_q;
  logic [8:0]        rem_q;
  logic [8:0]        q_q;
  logic [15:0]       res_q, quot_q;
  logic [3:0]        resf_q, flags_q;
  logic              out_valid_q;

  cls_e              cls_a_w, cls_b_w;
  logic              sign_w;
  logic              special_w;
  logic [15:0]       spec_res_w;
  logic [3:0]        spec_flags_w;
  logic signed [9:0] exp_tmp_w;
  logic signed [9:0] exp_n_w;
  logic [MAN_W-1:0]  mant_w;
  logic [15:0]       norm_res_w;
  logic [3:0]        norm_flags_w;
  logic [8:0]        rem_next_w;
  logic              qbit_w;

  assign cls_a_w   = bf16_classify(flp_a[14:0]);
  assign cls_b_w   = bf16_classify(flp_b[14:0]);
  assign sign_w    = flp_a[15] ^ flp_b[15];
  assign exp_tmp_w = $signed({2'b00, flp_a[14:7]}) - $signed({2'b00, flp_b[14:7]})
                   + $signed(10'(BIAS));

  always_comb begin
    special_w    = 1'b1;
    spec_res_w   = {sign_w, EXP_MAX, 7'd0};
    spec_flags_w = 4'b0000;
    if (cls_a_w == CLS_NAN || cls_b_w == CLS_NAN ||
        (cls_a_w == CLS_ZERO && cls_b_w == CLS_ZERO) ||
        (cls_a_w == CLS_INF && cls_b_w == CLS_INF)) begin
      spec_res_w   = QNAN;
      spec_flags_w = 4'b1000;
    end else if (cls_b_w == CLS_ZERO) begin
      spec_flags_w = 4'b0100;
    end else if (cls_a_w == CLS_INF) begin
      spec_flags_w = 4'b0000;
    end else if (cls_a_w == CLS_ZERO || cls_b_w == CLS_INF) begin
      spec_res_w   = {sign_w, 8'h00, 7'd0};
    end else begin
      special_w    = 1'b0;
    end
  end

  bf16_div_step u_step (
    .rem_i      (rem_q),
    .mb_i       (mb_q),
    .rem_next_o (rem_next_w),
    .qbit_o     (qbit_w)
  );

  // Mantissas are in [1,2), so the quotient lies in (0.5,2): q[8] or q[7] is set.
  always_comb begin
    if (q_q[8]) begin
      mant_w  = q_q[7:1];
      exp_n_w = exp_q;
    end else begin
      mant_w  = q_q[6:0];
      exp_n_w = exp_q - 10'sd1;
    end
    norm_res_w   = {sign_q, exp_n_w[7:0], mant_w};
    norm_flags_w = 4'b0000;
    if (exp_n_w >= 10'sd255) begin
      norm_res_w   = {sign_q, EXP_MAX, 7'd0};
      norm_flags_w = 4'b0010;
    end else if (exp_n_w <= 10'sd0) begin
      norm_res_w   = {sign_q, 8'h00, 7'd0};
      norm_flags_w = 4'b0001;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d = special_w ? ST_DONE : ST_DIV;
        cnt_d   = 4'd0;
      end
      ST_DIV: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) state_d = ST_NORM;
      end
      ST_NORM: state_d = ST_DONE;
      default: if (out_valid_q && out_ready) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mb_q        <= 8'd0;
      rem_q       <= 9'd0;
      q_q         <= 9'd0;
      res_q       <= 16'd0;
      resf_q      <= 4'd0;
      quot_q      <= 16'd0;
      flags_q     <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          sign_q <= sign_w;
          res_q  <= spec_res_w;
          resf_q <= spec_flags_w;
          exp_q  <= exp_tmp_w;
          rem_q  <= {2'b01, flp_a[6:0]};
          mb_q   <= {1'b1, flp_b[6:0]};
          q_q    <= 9'd0;
        end
        ST_DIV: begin
          rem_q <= rem_next_w;
          q_q   <= {q_q[7:0], qbit_w};
        end
        ST_NORM: begin
          res_q  <= norm_res_w;
          resf_q <= norm_flags_w;
        end
        default: begin
          // Output register loads once on entry to DONE, then holds until accepted.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            quot_q      <= res_q;
            flags_q     <= resf_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_bf16_div_seq.sv
`default_nettype none
// ============================================================================
// tb_bf16_div_seq
// Directed-vector bench with a queue scoreboard for the bfloat16 divider.
// Rev 1.0 - initial release
// ============================================================================
module tb_bf16_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] flp_a = 16'h0000;
  logic [15:0] flp_b = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quot;
  logic [3:0]  flags;

  bf16_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops on each rising out_valid, checks hold stability otherwise.
  logic        prev_v = 1'b0;
  logic [15:0] held_q = 16'h0;
  logic [3:0]  held_f = 4'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("quot", 32'(quot), 32'(e.q));
          check("flags", 32'(flags), 32'(e.f));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        held_q = quot;
        held_f = flags;
      end else if (out_valid) begin
        check("hold_quot", 32'(quot), 32'(held_q));
        check("hold_flags", 32'(flags), 32'(held_f));
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [3:0] ef, input int lat);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    flp_a    = a;
    flp_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flp_a    = 16'hDEAD;
    flp_b    = 16'hBEEF;
    e.q = eq; e.f = ef; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quot), 32'h0000);
    check("rst_flags", 32'(flags), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Normal path
    issue(16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 11);
    issue(16'h4040, 16'h4000, 16'h3FC0, 4'b0000, 11);
    issue(16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 11);
    issue(16'hC000, 16'h4000, 16'hBF80, 4'b0000, 11);
    // Special cases
    issue(16'h3F80, 16'h0000, 16'h7F80, 4'b0100, 1);
    issue(16'h0000, 16'h0000, 16'h7FC0, 4'b1000, 1);
    issue(16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000, 1);
    issue(16'hFF80, 16'h4000, 16'hFF80, 4'b0000, 1);
    issue(16'h4000, 16'h7F80, 16'h0000, 4'b0000, 1);
    // Range limits
    issue(16'h7F00, 16'h3E80, 16'h7F80, 4'b0010, 11);
    issue(16'h0080, 16'h4000, 16'h0000, 4'b0001, 11);
    drain();

    // Backpressure
    out_ready = 1'b0;
    issue(16'h4040, 16'h4000, 16'h3FC0, 4'b0000, 11);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_dropped", 32'(out_valid), 32'd0);
    issue(16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 11);
    drain();

    // Asynchronous reset during the fourth divide iteration
    issue(16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 11);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_quot", 32'(quot), 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h4040, 16'h4000, 16'h3FC0, 4'b0000, 11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
